// File: rtl/fu_output_queue.sv
// fu_output_queue
// Result buffer between a functional unit and the common data bus (CDB).
// The FU pushes {value, tag} pairs. An arbiter grants the bus one cycle at a
// time through data_bus_permit, and a granted cycle with a held entry pops the
// head onto the bus. Entries leave in the order they were pushed. A pushed
// entry first becomes visible on the cycle after the push.
module fu_output_queue #(
   parameter int XLEN      = 32,
   parameter int TAG_WIDTH = 32,
   parameter int DEPTH     = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic [XLEN-1:0]            value,
   input  logic [TAG_WIDTH-1:0]       tag,
   input  logic                       write_en,
   input  logic                       data_bus_permit,
   output tri   [XLEN-1:0]            data_bus_data,
   output tri   [TAG_WIDTH-1:0]       data_bus_tag,
   output logic                       not_empty,
   output logic                       full,
   output logic                       accept,
   output logic                       overflow,
   output logic [$clog2(DEPTH):0]     count,
   output logic [$clog2(DEPTH)-1:0]   read_from,
   output logic [$clog2(DEPTH)-1:0]   write_to
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   // Entry storage. It is never cleared, because a valid entry is only ever
   // read between the head and tail pointers.
   logic [XLEN-1:0]      value_mem_r [DEPTH];
   logic [TAG_WIDTH-1:0] tag_mem_r   [DEPTH];

   // Architectural state.
   logic [PTR_W-1:0] read_from_r;
   logic [PTR_W-1:0] write_to_r;
   logic [CNT_W-1:0] count_r;
   logic             overflow_r;

   // Next-state values.
   logic [PTR_W-1:0] read_from_nxt_s;
   logic [PTR_W-1:0] write_to_nxt_s;
   logic [CNT_W-1:0] count_nxt_s;
   logic             overflow_nxt_s;

   // Handshake decode.
   logic not_empty_s;
   logic full_s;
   logic pop_s;
   logic accept_s;
   logic push_s;

   // Decode the status flags and the push/pop handshake from the held state.
   // Status is forced low during reset, so no stale entry can be granted.
   always_comb begin
      not_empty_s = 1'b0;
      full_s      = 1'b0;
      pop_s       = 1'b0;
      accept_s    = 1'b0;
      push_s      = 1'b0;
      if (reset) begin
         not_empty_s = 1'b0;
         full_s      = 1'b0;
      end else begin
         not_empty_s = (count_r != {CNT_W{1'b0}});
         full_s      = (count_r == DEPTH_C);
      end
      pop_s    = data_bus_permit && not_empty_s;
      // A pop in the same cycle frees a slot, so a full queue still takes the push.
      accept_s = write_en && (!full_s || pop_s) && !flush;
      push_s   = accept_s && !reset;
   end

   // Compute the next pointers, count and overflow flag. Reset has priority
   // over flush, and flush has priority over push and pop.
   always_comb begin
      read_from_nxt_s = read_from_r;
      write_to_nxt_s  = write_to_r;
      count_nxt_s     = count_r;
      overflow_nxt_s  = 1'b0;
      if (reset) begin
         read_from_nxt_s = {PTR_W{1'b0}};
         write_to_nxt_s  = {PTR_W{1'b0}};
         count_nxt_s     = {CNT_W{1'b0}};
         overflow_nxt_s  = 1'b0;
      end else if (flush) begin
         read_from_nxt_s = {PTR_W{1'b0}};
         write_to_nxt_s  = {PTR_W{1'b0}};
         count_nxt_s     = {CNT_W{1'b0}};
         overflow_nxt_s  = 1'b0;
      end else begin
         if (pop_s) begin
            read_from_nxt_s = read_from_r + PTR_W'(1);
         end else begin
            read_from_nxt_s = read_from_r;
         end
         if (push_s) begin
            write_to_nxt_s = write_to_r + PTR_W'(1);
         end else begin
            write_to_nxt_s = write_to_r;
         end
         case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
         endcase
         // A push that was refused while not flushing was lost. Raise the
         // flag for one cycle.
         overflow_nxt_s = write_en && !accept_s;
      end
   end

   // Update the pointer, count and overflow registers.
   always_ff @(posedge clk) begin
      read_from_r <= read_from_nxt_s;
      write_to_r  <= write_to_nxt_s;
      count_r     <= count_nxt_s;
      overflow_r  <= overflow_nxt_s;
   end

   // Write an accepted entry into the tail slot.
   always_ff @(posedge clk) begin
      if (push_s) begin
         value_mem_r[write_to_r] <= value;
         tag_mem_r[write_to_r]   <= tag;
      end
   end

   // Drive the head entry onto the shared bus only while this queue pops.
   // The bus is released to high-Z in every other cycle.
   assign data_bus_data = pop_s ? value_mem_r[read_from_r] : {XLEN{1'bz}};
   assign data_bus_tag  = pop_s ? tag_mem_r[read_from_r]   : {TAG_WIDTH{1'bz}};

   assign not_empty = not_empty_s;
   assign full      = full_s;
   assign accept    = accept_s;
   assign overflow  = overflow_r;
   assign count     = count_r;
   assign read_from = read_from_r;
   assign write_to  = write_to_r;

endmodule

// File: tb/tb_fu_output_queue.sv
// tb_fu_output_queue
// Directed and random stimulus for fu_output_queue. The reference model keeps
// the held entries in a queue and keeps the pointers as running push/pop
// totals taken modulo DEPTH. Pull-ups on the bus make a released bus read as
// all ones. Random data never uses all ones, so the idle value cannot be
// mistaken for a driven entry.
module tb_fu_output_queue;

   localparam int XLEN      = 32;
   localparam int TAG_WIDTH = 32;
   localparam int DEPTH     = 4;
   localparam int PTR_W     = $clog2(DEPTH);

   logic                  clk;
   logic                  reset;
   logic                  flush;
   logic [XLEN-1:0]       value;
   logic [TAG_WIDTH-1:0]  tag;
   logic                  write_en;
   logic                  data_bus_permit;
   wire  [XLEN-1:0]       data_bus_data;
   wire  [TAG_WIDTH-1:0]  data_bus_tag;
   logic                  not_empty;
   logic                  full;
   logic                  accept;
   logic                  overflow;
   logic [PTR_W:0]        count;
   logic [PTR_W-1:0]      read_from;
   logic [PTR_W-1:0]      write_to;

   pullup (data_bus_data);
   pullup (data_bus_tag);

   fu_output_queue #(.XLEN(XLEN), .TAG_WIDTH(TAG_WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .flush(flush), .value(value), .tag(tag),
      .write_en(write_en), .data_bus_permit(data_bus_permit),
      .data_bus_data(data_bus_data), .data_bus_tag(data_bus_tag),
      .not_empty(not_empty), .full(full), .accept(accept), .overflow(overflow),
      .count(count), .read_from(read_from), .write_to(write_to)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   logic [XLEN+TAG_WIDTH-1:0] mq[$];
   int unsigned               m_pushes;
   int unsigned               m_pops;
   logic                      m_ovf;

   int n_cmp;
   int n_err;

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // One clock cycle. Inputs are applied 1 time unit after the rising edge,
   // outputs are checked mid-cycle, and the model advances at the edge.
   task automatic step(input logic rst, input logic fl, input logic we,
                       input logic [XLEN-1:0] v, input logic [TAG_WIDTH-1:0] t,
                       input logic pm);
      logic e_ne, e_full, e_pop, e_acc;
      logic [XLEN-1:0]      e_data;
      logic [TAG_WIDTH-1:0] e_tag;
      reset = rst; flush = fl; write_en = we; value = v; tag = t; data_bus_permit = pm;
      #4;
      e_ne   = !rst && (mq.size() > 0);
      e_full = !rst && (mq.size() == DEPTH);
      e_pop  = pm && e_ne;
      e_acc  = we && (!e_full || e_pop) && !fl;
      e_data = '1;
      e_tag  = '1;
      if (e_pop) begin
         e_data = mq[0][XLEN+TAG_WIDTH-1:TAG_WIDTH];
         e_tag  = mq[0][TAG_WIDTH-1:0];
      end
      check("not_empty", 64'(not_empty), 64'(e_ne));
      check("full",      64'(full),      64'(e_full));
      check("accept",    64'(accept),    64'(e_acc));
      check("count",     64'(count),     64'(mq.size()));
      check("read_from", 64'(read_from), 64'(m_pops % DEPTH));
      check("write_to",  64'(write_to),  64'(m_pushes % DEPTH));
      check("overflow",  64'(overflow),  64'(m_ovf));
      check("bus_data",  64'(data_bus_data), 64'(e_data));
      check("bus_tag",   64'(data_bus_tag),  64'(e_tag));
      if (rst || fl) begin
         mq.delete();
         m_pushes = 0;
         m_pops   = 0;
         m_ovf    = 1'b0;
      end else begin
         m_ovf = we && !e_acc;
         if (e_pop) begin
            void'(mq.pop_front());
            m_pops++;
         end
         if (e_acc) begin
            mq.push_back({v, t});
            m_pushes++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic pm);
      step(1'b0, 1'b0, 1'b0, '0, '0, pm);
   endtask

   task automatic push(input logic [XLEN-1:0] v, input logic [TAG_WIDTH-1:0] t, input logic pm);
      step(1'b0, 1'b0, 1'b1, v, t, pm);
   endtask

   function automatic logic [31:0] rnd_word();
      logic [31:0] w;
      w = $urandom;
      if (w == 32'hFFFF_FFFF) begin
         w = 32'h0;
      end
      return w;
   endfunction

   initial begin
      n_cmp = 0; n_err = 0;
      m_pushes = 0; m_pops = 0; m_ovf = 1'b0;
      reset = 1'b1; flush = 1'b0; write_en = 1'b0; data_bus_permit = 1'b0;
      value = '0; tag = '0;
      @(posedge clk);
      #1;
      step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 32'd7, 32'd7, 1'b1);

      // Single push, no bus bypass, then a granted pop of 41/19
      push(32'd41, 32'd19, 1'b0);
      idle(1'b1);
      idle(1'b0);

      // Fill, drop on full, then push plus pop while full
      for (int i = 1; i <= 4; i++) push(32'(100 + i), 32'(i), 1'b0);
      push(32'd105, 32'd5, 1'b0);
      idle(1'b0);
      push(32'd106, 32'd6, 1'b1);
      for (int i = 0; i < 4; i++) idle(1'b1);

      // Interleaved pushes and pops that wrap both pointers
      push(32'd201, 32'd1, 1'b0);
      for (int i = 2; i <= 6; i++) push(32'(200 + i), 32'(i), 1'b1);
      idle(1'b1);
      idle(1'b1);

      // Flush with a push and a permit in the same cycle
      for (int i = 1; i <= 3; i++) push(32'(300 + i), 32'(30 + i), 1'b0);
      step(1'b0, 1'b1, 1'b1, 32'd399, 32'd39, 1'b1);
      idle(1'b1);
      idle(1'b0);

      // Permit on an empty queue, then reset with two entries held
      idle(1'b1);
      push(32'd501, 32'd51, 1'b0);
      push(32'd502, 32'd52, 1'b0);
      step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
      idle(1'b1);
      idle(1'b1);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         logic r_rst, r_fl, r_we, r_pm;
         r_rst = ($urandom_range(99) < 2);
         r_fl  = ($urandom_range(99) < 4);
         r_we  = ($urandom_range(99) < 60);
         r_pm  = ($urandom_range(99) < 45);
         step(r_rst, r_fl, r_we, rnd_word(), rnd_word(), r_pm);
      end
      for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
